// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
package fifo_sched_pkg;

  // Two-phase scheduler: pick a source, then stream a burst from it.
  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  // Width of a source index; a single source still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (base + off) mod n, valid while base < n and off <= n.
  // One conditional subtract avoids a divider for non-power-of-2 n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin winner search: rotate the request vector so the entry right
// after the previous grant sits at bit 0, priority-encode, then rotate the
// found position back to a real source index.
module rr_priority_select
  import fifo_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          found,
  output logic [SW-1:0] winner
);

  logic [N-1:0]  rot;
  logic [SW-1:0] first;

  // Rotated view: rot[k] is the request of source (last + 1 + k) mod N.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req[SW'(wrap_add(int'(last), k + 1, N))];
    end
  end

  // Lowest set bit of the rotated vector is the nearest requester.
  always_comb begin
    found = 1'b0;
    first = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        first = SW'(k);
      end
    end
  end

  // Undo the rotation to recover the absolute source index.
  assign winner = SW'(wrap_add(int'(last), int'(first) + 1, N));

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains NUM_SRC first-word-fall-through FIFOs onto one valid/ready stream,
// round-robin between enabled non-empty sources, up to MAX_BURST words per
// grant.
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high; the same edge pops the granted FIFO via src_read. Once
// out_valid is high, out_valid/out_data/out_src hold until that transfer,
// because only this block pops the granted FIFO.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_empty,
  input  logic [NUM_SRC*WIDTH-1:0]    src_data,
  output logic [NUM_SRC-1:0]          src_read,
  input  logic [NUM_SRC-1:0]          src_enable,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [idx_w(NUM_SRC)-1:0]   out_src,
  output logic                        out_last
);

  localparam int SW = idx_w(NUM_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  sched_state_t      state;
  logic [SW-1:0]     grant;
  logic [SW-1:0]     last_grant;
  logic [CW-1:0]     beat_cnt;

  logic [NUM_SRC-1:0] req;
  logic               found;
  logic [SW-1:0]      winner;
  logic [WIDTH-1:0]   words [NUM_SRC];
  logic               handshake;

  // Only enabled sources holding data compete for the next grant.
  assign req = src_enable & ~src_empty;

  rr_priority_select #(
    .N  (NUM_SRC),
    .SW (SW)
  ) u_select (
    .req    (req),
    .last   (last_grant),
    .found  (found),
    .winner (winner)
  );

  // Split the flattened source data bus into one word per source.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      words[i] = src_data[i*WIDTH +: WIDTH];
    end
  end

  // Output stream follows the granted FIFO head while bursting. Reset
  // suppresses valid and read so a word under reset stays in its FIFO.
  always_comb begin
    out_valid = (state == BURST) && !src_empty[grant] && !rst;
    handshake = out_valid && out_ready;
    out_data  = words[grant];
    out_src   = grant;
    out_last  = out_valid && (beat_cnt == LAST_BEAT);
    src_read  = '0;
    if (handshake) begin
      src_read[grant] = 1'b1;
    end
  end

  // Scheduler FSM: ARB picks the next source (always at least one cycle),
  // BURST streams from it until MAX_BURST words or the source runs dry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      grant      <= '0;
      last_grant <= SW'(NUM_SRC - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        ARB: begin
          if (found) begin
            grant    <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (!out_valid) begin
            // Source drained: end the burst early, no pop this cycle.
            state      <= ARB;
            last_grant <= grant;
          end else if (out_ready) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (beat_cnt == LAST_BEAT) begin
              state      <= ARB;
              last_grant <= grant;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
